// File: rtl/pipeline_drain_fifo.sv
// Drain FIFO at the tail of a pipeline: FWFT output, skid-based stall, sticky overflow.
// Define PIPELINE_DRAIN_FIFO_STATS_EN to enable the stat_words/stat_stalls counters.
module pipeline_drain_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SKID  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic                       stall,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                stat_words,
  output logic [15:0]                stat_stalls
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - SKID);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             ovf;
  logic             pop;
  logic             push;
  logic             drop;

  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = cnt;
  assign overflow  = ovf;
  assign stall     = (cnt >= THRESH);

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && ((cnt != FULL) || pop);
  assign drop = in_valid && (cnt == FULL) && !pop;

  always_ff @(posedge clk) begin
    if (reset_n && !flush && push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push && !pop): cnt <= cnt + (AW+1)'(1);
        (pop && !push): cnt <= cnt - (AW+1)'(1);
        default:        cnt <= cnt;
      endcase
      if (drop)
        ovf <= 1'b1;
    end
  end

`ifdef PIPELINE_DRAIN_FIFO_STATS_EN
  logic [15:0] words_q;
  logic [15:0] stalls_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (push && !flush && !(&words_q))
        words_q <= words_q + 16'd1;
      if (stall && !(&stalls_q))
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_pipeline_drain_fifo.sv
// Bench for pipeline_drain_fifo: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_pipeline_drain_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SKID  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              stall;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        level;
  logic              overflow;
  logic [15:0]       stat_words;
  logic [15:0]       stat_stalls;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  pipeline_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .stall(stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .stat_words(stat_words), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of words plus flags.
  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 1'b0;
  int m_words = 0;
  int m_stalls = 0;

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_words = 0;
      m_stalls = 0;
    end else begin
`ifdef PIPELINE_DRAIN_FIFO_STATS_EN
      if (mq.size() >= DEPTH - SKID && m_stalls < 65535)
        m_stalls++;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = in_valid && (mq.size() < DEPTH || do_pop);
        if (in_valid && !do_push)
          m_ovf = 1'b1;
`ifdef PIPELINE_DRAIN_FIFO_STATS_EN
        if (do_push && m_words < 65535)
          m_words++;
`endif
        if (do_pop)
          void'(mq.pop_front());
        if (do_push)
          mq.push_back(in_data);
      end
    end
  end

  task automatic ck(input string name, input logic [31:0] act,
                    input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      ck("m_level", 32'(level), 32'(mq.size()));
      ck("m_valid", 32'(out_valid), 32'(mq.size() != 0));
      ck("m_stall", 32'(stall), 32'(mq.size() >= DEPTH - SKID));
      ck("m_ovf", 32'(overflow), 32'(m_ovf));
      ck("m_swords", 32'(stat_words), 32'(m_words));
      ck("m_sstalls", 32'(stat_stalls), 32'(m_stalls));
      if (mq.size() != 0)
        ck("m_data", out_data, mq[0]);
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] d,
                     input logic rdy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  logic [31:0] last;
  logic [31:0] got[$];
  int pushed;

  initial begin
    @(negedge clk);
    do_reset();
    run = 1'b1;
    ck("rst_level", 32'(level), 0);
    ck("rst_valid", 32'(out_valid), 0);
    ck("rst_stall", 32'(stall), 0);
    ck("rst_ovf", 32'(overflow), 0);

    // Single push, FWFT
    cyc(1, 32'hA5A5_0001, 0, 0);
    ck("fwft_valid", 32'(out_valid), 1);
    ck("fwft_data", out_data, 32'hA5A5_0001);
    ck("fwft_level", 32'(level), 1);

    // Fill to full, watching the stall threshold
    for (int i = 2; i <= 8; i++) begin
      cyc(1, 32'h100 + 32'(i), 0, 0);
      if (i == 4) ck("stall_lvl4", 32'(stall), 0);
      if (i == 5) ck("stall_lvl5", 32'(stall), 1);
    end
    ck("full_level", 32'(level), 8);

    // Push and pop while full
    cyc(1, 32'hBEEF_0000, 1, 0);
    ck("pp_level", 32'(level), 8);
    ck("pp_ovf", 32'(overflow), 0);
    ck("pp_head", out_data, 32'h102);
    last = '0;
    for (int i = 0; i < 8; i++) begin
      last = out_data;
      cyc(0, 0, 1, 0);
    end
    ck("pp_last", last, 32'hBEEF_0000);
    ck("pp_empty", 32'(level), 0);

    // Overflow on a 9th push into a full FIFO
    for (int i = 0; i < 8; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
    cyc(1, 32'hDEAD_DEAD, 0, 0);
    ck("ovf_set", 32'(overflow), 1);
    ck("ovf_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      last = out_data;
      cyc(0, 0, 1, 0);
    end
    ck("ovf_lost", last, 32'h207);
    ck("ovf_sticky", 32'(overflow), 1);

    // 20 words with toggling ready, across pointer wrap
    do_reset();
    ck("rst_ovf_clr", 32'(overflow), 0);
    pushed = 0;
    got.delete();
    for (int c = 0; c < 80; c++) begin
      logic rdy;
      logic iv;
      rdy = (c % 2 == 0);
      iv = (pushed < 20) && !stall;
      if (out_valid && rdy) got.push_back(out_data);
      cyc(iv, 32'(pushed), rdy, 0);
      if (iv) pushed++;
    end
    ck("wrap_count", 32'(got.size()), 20);
    if (got.size() == 20) begin
      ck("wrap_w7", got[7], 7);
      ck("wrap_w19", got[19], 19);
    end
    ck("wrap_ovf", 32'(overflow), 0);

    // Flush with a simultaneous push
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i), 0, 0);
    ck("fl_pre", 32'(level), 4);
    cyc(1, 32'h3FF, 1, 1);
    ck("fl_level", 32'(level), 0);
    ck("fl_valid", 32'(out_valid), 0);
    ck("fl_stall", 32'(stall), 0);
    cyc(1, 32'h400, 0, 0);
    ck("fl_next", out_data, 32'h400);
    ck("fl_next_lvl", 32'(level), 1);

    // Statistics: 10 pushes, 3 stall cycles
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 32'h500 + 32'(i), 1, 0);
    for (int i = 5; i < 10; i++) cyc(1, 32'h500 + 32'(i), 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef PIPELINE_DRAIN_FIFO_STATS_EN
    ck("st_words", 32'(stat_words), 10);
    ck("st_stalls", 32'(stat_stalls), 3);
`else
    ck("st_words", 32'(stat_words), 0);
    ck("st_stalls", 32'(stat_stalls), 0);
`endif
    ck("st_level", 32'(level), 6);

    // Reset mid-stream
    reset_n = 1'b0;
    cyc(1, 32'h600, 1, 0);
    ck("mr_level", 32'(level), 0);
    ck("mr_valid", 32'(out_valid), 0);
    ck("mr_stall", 32'(stall), 0);
    ck("mr_ovf", 32'(overflow), 0);
    ck("mr_words", 32'(stat_words), 0);
    ck("mr_stalls", 32'(stat_stalls), 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    ck("mr_after", 32'(out_valid), 0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
